cmsdk_apb_watchdog_ctrl: RTL and testbench
==========================================

# cmsdk_apb_watchdog_ctrl

APB master sequencer that configures and services the APB watchdog without CPU involvement. Turns single-cycle requests (start, kick, stop, read) into the required APB register sequences, including unlock and relock of the lock register. Contains an optional auto-kick timer. Sits between system control logic and the watchdog's APB slave port, on the same PCLK.

## Interface
- KICK_W, 16, width of auto-kick period counter
- PCLK  in  1  APB clock, sole clock
- PRESET  in  1  synchronous, active-high reset
- start_req  in  1  pulse: program and enable watchdog
- cfg_load  in  32  LOAD value used by start
- cfg_inten  in  1  CONTROL[0] value used by start
- cfg_resen  in  1  CONTROL[1] value used by start
- kick_req  in  1  pulse: clear interrupt / reload counter
- stop_req  in  1  pulse: disable watchdog
- rd_req  in  1  pulse: read VALUE register
- auto_kick_en  in  1  enable internal kick timer
- kick_period  in  KICK_W  PCLK cycles between auto kicks; 0 = no auto kick
- PSEL, PENABLE, PWRITE  out  1  APB master controls
- PADDR  out  10  word address [11:2]
- PWDATA  out  32  write data
- PRDATA  in  32  slave read data
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at end of any sequence
- done_op  out  2  op just completed: 0 start, 1 kick, 2 stop, 3 read
- rd_data  out  32  last VALUE read
- rd_valid  out  1  one-cycle pulse, rd_data updated
- running  out  1  set by completed start, cleared by completed stop

## Operation
- Word addresses: LOAD 0x000, VALUE 0x001, CONTROL 0x002, INTCLR 0x003, LOCK 0x300. Unlock key 0x1ACCE551; relock data 0x00000000.
- Sequences, in transfer order:
  - start: LOCK←key, LOAD←cfg_load, CONTROL←{30'b0,cfg_resen,cfg_inten}, LOCK←0. 4 transfers. cfg_* sampled at the first SETUP.
  - kick: LOCK←key, INTCLR←0x00000001, LOCK←0. 3 transfers.
  - stop: LOCK←key, CONTROL←0, LOCK←0. 3 transfers.
  - read: read VALUE. 1 transfer, no unlock.
- Each request pulse sets a sticky pending bit. Repeat pulses of the same type merge. Pending bits are cleared when their sequence is launched.
- Launch priority among pending bits: stop > start > kick > read. A sequence in progress is never preempted.
- kick_req and auto-kick requests while running=0 are dropped; they set no pending bit.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE→SETUP when any pending bit is set; loads op and step=0.
  - SETUP→ACCESS always.
  - ACCESS→SETUP if more steps remain (step++); otherwise ACCESS→IDLE with done asserted.
- Auto-kick counter:
  - Counts PCLK cycles while running & auto_kick_en & kick_period≠0; otherwise held at 0.
  - On reaching kick_period−1: sets kick pending and reloads 0.
  - Counting continues while busy.
- running: set on completion of start, cleared on completion of stop.

## Timing
- Request pulse in cycle N → pending set at edge N → PSEL=1, PENABLE=0 in cycle N+1 if IDLE.
- Each transfer takes exactly 2 cycles: SETUP then ACCESS. The slave has no wait states.
- Transfers within a sequence are back-to-back: PSEL stays 1, PENABLE toggles.
- PADDR, PWRITE and PWDATA are stable across SETUP and ACCESS of a transfer.
- Read: rd_data←PRDATA captured at the end of the ACCESS cycle.
- done, done_op and rd_valid (read only) are asserted in the cycle after the last ACCESS, with PSEL=0.
- A pending op launches at the earliest from the cycle after done, giving at least one idle cycle between sequences.
- Sequence durations from launch (first SETUP) to done: start 9 cycles, kick 7, stop 7, read 3.
- busy = pending≠0 or state≠IDLE.
- PRESET (synchronous, mid-sequence allowed): at the next edge, FSM→IDLE and pending, counter and running are cleared. PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, busy=done=rd_valid=0, rd_data=0, done_op=0.
- A request pulsed in the same cycle as PRESET is lost.

## Test plan
- start_req, cfg_load=0x00000100, inten=1, resen=1 → writes LOCK←0x1ACCE551, LOAD←0x100, CONTROL←0x3, LOCK←0. Watchdog lock reads 1 afterward; done with done_op=0, running=1.
- kick_req while running → INTCLR write between unlock and relock, WDOGINT deasserts. kick_req while not running → no APB activity, busy stays 0.
- start_req, stop_req and kick_req pulsed in the same cycle from running=1 → order is stop, then start, then kick. Three done pulses with done_op 2, 0, 1.
- auto_kick_en=1, kick_period=20, cfg_load=0x40, resen=1 → kick sequences every 20 cycles and WDOGRES never asserts. Set auto_kick_en=0 → WDOGRES asserts after the counter expires twice.
- rd_req after start with WDOGCLKEN=0 → rd_valid pulse, rd_data=0x00000100, PSEL high for exactly 2 cycles.
- PRESET asserted during the ACCESS of the second start transfer → PSEL=0 next cycle, busy=0, running=0, no done pulse, pending requests cleared.

Source files
------------

// File: rtl/cmsdk_apb_watchdog_ctrl.sv
// APB master sequencer for the CMSDK watchdog: turns start/kick/stop/read
// request pulses into unlock / program / relock register sequences.
module cmsdk_apb_watchdog_ctrl #(
  parameter int KICK_W = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              start_req,
  input  logic [31:0]       cfg_load,
  input  logic              cfg_inten,
  input  logic              cfg_resen,
  input  logic              kick_req,
  input  logic              stop_req,
  input  logic              rd_req,
  input  logic              auto_kick_en,
  input  logic [KICK_W-1:0] kick_period,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [9:0]        PADDR,
  output logic [31:0]       PWDATA,
  input  logic [31:0]       PRDATA,
  output logic              busy,
  output logic              done,
  output logic [1:0]        done_op,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic              running
);

  localparam logic [9:0]  ADDR_LOAD   = 10'h000;
  localparam logic [9:0]  ADDR_VALUE  = 10'h001;
  localparam logic [9:0]  ADDR_CTRL   = 10'h002;
  localparam logic [9:0]  ADDR_INTCLR = 10'h003;
  localparam logic [9:0]  ADDR_LOCK   = 10'h300;
  localparam logic [31:0] UNLOCK_KEY  = 32'h1ACCE551;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_KICK  = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_READ  = 2'd3;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  typedef struct packed {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] data;
  } xfer_t;

  state_t            state;
  logic [1:0]        op;
  logic [1:0]        step;
  logic [3:0]        pend;
  logic [3:0]        req_vec;
  logic [3:0]        pend_eff;
  logic [1:0]        launch_op;
  logic [KICK_W-1:0] cnt;
  logic              cnt_en;
  logic              auto_tick;
  logic [31:0]       load_lat;
  logic [1:0]        ctrl_lat;

  function automatic logic [1:0] last_step(input logic [1:0] o);
    case (o)
      OP_START: last_step = 2'd3;
      OP_READ:  last_step = 2'd0;
      default:  last_step = 2'd2;
    endcase
  endfunction

  // Register transfer for step s of sequence o; every write sequence opens
  // with the unlock key and closes by relocking.
  function automatic xfer_t seq_xfer(input logic [1:0] o, input logic [1:0] s,
                                     input logic [31:0] ld, input logic [1:0] ctl);
    seq_xfer = '{wr: 1'b1, addr: ADDR_LOCK, data: 32'h0};
    if (o == OP_READ) begin
      seq_xfer = '{wr: 1'b0, addr: ADDR_VALUE, data: 32'h0};
    end else if (s == 2'd0) begin
      seq_xfer.data = UNLOCK_KEY;
    end else if (s == 2'd1) begin
      case (o)
        OP_START: seq_xfer = '{wr: 1'b1, addr: ADDR_LOAD, data: ld};
        OP_KICK:  seq_xfer = '{wr: 1'b1, addr: ADDR_INTCLR, data: 32'h1};
        default:  seq_xfer = '{wr: 1'b1, addr: ADDR_CTRL, data: 32'h0};
      endcase
    end else if (s == 2'd2 && o == OP_START) begin
      seq_xfer = '{wr: 1'b1, addr: ADDR_CTRL, data: {30'b0, ctl}};
    end
  endfunction

  always_comb begin
    cnt_en    = running && auto_kick_en && (kick_period != '0);
    auto_tick = cnt_en && (cnt == kick_period - KICK_W'(1));
    req_vec           = 4'b0;
    req_vec[OP_START] = start_req;
    req_vec[OP_KICK]  = (kick_req || auto_tick) && running;
    req_vec[OP_STOP]  = stop_req;
    req_vec[OP_READ]  = rd_req;
    // New pulses are folded in so an idle sequencer launches on the same edge.
    pend_eff = pend | req_vec;
    if (pend_eff[OP_STOP])       launch_op = OP_STOP;
    else if (pend_eff[OP_START]) launch_op = OP_START;
    else if (pend_eff[OP_KICK])  launch_op = OP_KICK;
    else                         launch_op = OP_READ;
  end

  assign busy = (pend != 4'b0) || (state != IDLE);

  always_ff @(posedge PCLK) begin
    if (PRESET || !cnt_en || auto_tick) cnt <= '0;
    else                                cnt <= cnt + KICK_W'(1);
  end

  always_ff @(posedge PCLK) begin
    if (state == SETUP && step == 2'd0 && op == OP_START) begin
      load_lat <= cfg_load;
      ctrl_lat <= {cfg_resen, cfg_inten};
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= IDLE;
      op       <= OP_START;
      step     <= 2'd0;
      pend     <= 4'b0;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      done     <= 1'b0;
      done_op  <= OP_START;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      running  <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      pend     <= pend_eff;
      case (state)
        IDLE: begin
          if (pend_eff != 4'b0) begin
            state   <= SETUP;
            op      <= launch_op;
            step    <= 2'd0;
            pend    <= pend_eff & ~(4'b0001 << launch_op);
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            {PWRITE, PADDR, PWDATA} <= seq_xfer(launch_op, 2'd0, load_lat, ctrl_lat);
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
        end
        default: begin
          if (step != last_step(op)) begin
            state   <= SETUP;
            step    <= step + 2'd1;
            PENABLE <= 1'b0;
            {PWRITE, PADDR, PWDATA} <= seq_xfer(op, step + 2'd1, load_lat, ctrl_lat);
          end else begin
            state   <= IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            done    <= 1'b1;
            done_op <= op;
            if (op == OP_READ) begin
              rd_data  <= PRDATA;
              rd_valid <= 1'b1;
            end
            if (op == OP_START) running <= 1'b1;
            if (op == OP_STOP)  running <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmsdk_apb_watchdog_ctrl.sv
// Directed bench for cmsdk_apb_watchdog_ctrl: APB transfer log, done order,
// sequence timing, auto-kick interval and mid-sequence reset.
module tb_cmsdk_apb_watchdog_ctrl;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        start_req, kick_req, stop_req, rd_req;
  logic [31:0] cfg_load;
  logic        cfg_inten, cfg_resen;
  logic        auto_kick_en;
  logic [15:0] kick_period;
  logic        PSEL, PENABLE, PWRITE;
  logic [9:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        busy, done, rd_valid, running;
  logic [1:0]  done_op;
  logic [31:0] rd_data;

  int n_chk = 0;
  int n_fail = 0;

  logic [42:0] xq[$];
  logic [1:0]  dq[$];
  int          dcyc[$];
  int          cyc = 0;
  int          psel_cnt = 0;
  int          rv_cnt = 0;
  logic [42:0] snap;

  always #5 PCLK = ~PCLK;

  // Slave model: VALUE frozen at the loaded value (watchdog clock disabled).
  assign PRDATA = (PSEL && PADDR == 10'h001) ? 32'h0000_0100 : 32'h0;

  cmsdk_apb_watchdog_ctrl #(.KICK_W(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .start_req(start_req), .cfg_load(cfg_load),
    .cfg_inten(cfg_inten), .cfg_resen(cfg_resen), .kick_req(kick_req),
    .stop_req(stop_req), .rd_req(rd_req), .auto_kick_en(auto_kick_en),
    .kick_period(kick_period), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .busy(busy), .done(done),
    .done_op(done_op), .rd_data(rd_data), .rd_valid(rd_valid), .running(running)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [42:0] xf(input logic w, input logic [9:0] a, input logic [31:0] d);
    return {w, a, d};
  endfunction

  always @(negedge PCLK) begin
    cyc++;
    if (PSEL) psel_cnt++;
    if (rd_valid) rv_cnt++;
    if (PSEL && !PENABLE) snap = {PWRITE, PADDR, PWDATA};
    if (PSEL && PENABLE) begin
      chk("stable", {21'b0, PWRITE, PADDR, PWDATA}, {21'b0, snap});
      xq.push_back({PWRITE, PADDR, PWDATA});
    end
    if (done) begin
      dq.push_back(done_op);
      dcyc.push_back(cyc);
    end
  end

  task automatic pulse(input int which);
    @(negedge PCLK);
    start_req = which[0]; kick_req = which[1]; stop_req = which[2]; rd_req = which[3];
    @(negedge PCLK);
    start_req = 0; kick_req = 0; stop_req = 0; rd_req = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    if (!done) chk("done_timeout", 64'd0, 64'd1);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge PCLK);
      n++;
    end
    chk("idle_timeout", {63'b0, busy}, 64'd0);
    #1;
  endtask

  task automatic check_seq(input string tag, input int base, input logic [42:0] e[$]);
    chk({tag, "_count"}, xq.size() - base, e.size());
    for (int i = 0; i < e.size() && base + i < xq.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), {21'b0, xq[base+i]}, {21'b0, e[i]});
  endtask

  initial begin
    int n, xb, db, pb, rb, idle_bad;
    logic [42:0] e[$];
    PRESET = 1; start_req = 0; kick_req = 0; stop_req = 0; rd_req = 0;
    cfg_load = 0; cfg_inten = 0; cfg_resen = 0; auto_kick_en = 0; kick_period = 0;
    repeat (3) @(negedge PCLK);
    chk("rst_psel", {63'b0, PSEL}, 0);
    chk("rst_busy", {63'b0, busy}, 0);
    chk("rst_running", {63'b0, running}, 0);
    chk("rst_rd_data", {32'b0, rd_data}, 0);
    chk("rst_paddr", {54'b0, PADDR}, 0);
    PRESET = 0;
    repeat (2) @(negedge PCLK);

    // start
    cfg_load = 32'h100; cfg_inten = 1; cfg_resen = 1;
    xb = xq.size();
    pulse(1);
    chk("start_setup_psel", {62'b0, PSEL, PENABLE}, 64'b10);
    chk("start_setup_addr", {54'b0, PADDR}, 64'h300);
    wait_done(n);
    chk("start_dur", n, 8);
    chk("start_done_op", {62'b0, done_op}, 0);
    chk("start_running", {63'b0, running}, 1);
    chk("start_done_psel", {63'b0, PSEL}, 0);
    e = {};
    e.push_back(xf(1, 10'h300, 32'h1ACCE551)); e.push_back(xf(1, 10'h000, 32'h100));
    e.push_back(xf(1, 10'h002, 32'h3));        e.push_back(xf(1, 10'h300, 32'h0));
    check_seq("start_seq", xb, e);

    // kick while running
    xb = xq.size();
    pulse(2);
    wait_done(n);
    chk("kick_dur", n, 6);
    chk("kick_done_op", {62'b0, done_op}, 1);
    e = {};
    e.push_back(xf(1, 10'h300, 32'h1ACCE551)); e.push_back(xf(1, 10'h003, 32'h1));
    e.push_back(xf(1, 10'h300, 32'h0));
    check_seq("kick_seq", xb, e);

    // simultaneous stop/start/kick
    xb = xq.size(); db = dq.size();
    pulse(7);
    wait_idle();
    chk("combo_ndone", dq.size() - db, 3);
    if (dq.size() - db == 3) begin
      chk("combo_op0", {62'b0, dq[db]}, 2);
      chk("combo_op1", {62'b0, dq[db+1]}, 0);
      chk("combo_op2", {62'b0, dq[db+2]}, 1);
      chk("combo_gap1", dcyc[db+1] - dcyc[db], 9);
      chk("combo_gap2", dcyc[db+2] - dcyc[db+1], 7);
    end
    chk("combo_nxfer", xq.size() - xb, 10);
    chk("combo_running", {63'b0, running}, 1);

    // read
    pb = psel_cnt; rb = rv_cnt; xb = xq.size();
    pulse(8);
    wait_done(n);
    chk("read_dur", n, 2);
    chk("read_done_op", {62'b0, done_op}, 3);
    chk("read_valid", {63'b0, rd_valid}, 1);
    chk("read_data", {32'b0, rd_data}, 64'h100);
    repeat (3) @(negedge PCLK);
    #1;
    chk("read_psel_cycles", psel_cnt - pb, 2);
    chk("read_valid_cycles", rv_cnt - rb, 1);
    e = {};
    e.push_back(xf(0, 10'h001, 32'h0));
    check_seq("read_seq", xb, e);

    // stop, then kick while stopped
    xb = xq.size();
    pulse(4);
    wait_done(n);
    chk("stop_done_op", {62'b0, done_op}, 2);
    chk("stop_running", {63'b0, running}, 0);
    e = {};
    e.push_back(xf(1, 10'h300, 32'h1ACCE551)); e.push_back(xf(1, 10'h002, 32'h0));
    e.push_back(xf(1, 10'h300, 32'h0));
    check_seq("stop_seq", xb, e);
    xb = xq.size(); idle_bad = 0;
    pulse(2);
    repeat (10) begin
      if (busy || PSEL) idle_bad++;
      @(negedge PCLK);
    end
    chk("kick_stopped_busy", idle_bad, 0);
    chk("kick_stopped_xfer", xq.size() - xb, 0);

    // auto-kick
    cfg_load = 32'h40; cfg_inten = 0; cfg_resen = 1;
    xb = xq.size();
    pulse(1);
    wait_done(n);
    chk("auto_start_ctrl", {21'b0, xq[xb+2]}, {21'b0, xf(1, 10'h002, 32'h2)});
    @(negedge PCLK);
    kick_period = 16'd20; auto_kick_en = 1;
    db = dq.size();
    repeat (75) @(negedge PCLK);
    #1;
    chk("auto_nkick", dq.size() - db, 3);
    if (dq.size() - db == 3) begin
      chk("auto_op", {62'b0, dq[db+2]}, 1);
      chk("auto_int1", dcyc[db+1] - dcyc[db], 20);
      chk("auto_int2", dcyc[db+2] - dcyc[db+1], 20);
    end
    auto_kick_en = 0;
    db = dq.size();
    repeat (60) @(negedge PCLK);
    #1;
    chk("auto_off_nkick", dq.size() - db, 0);
    kick_period = 16'd0; auto_kick_en = 1;
    db = dq.size();
    repeat (60) @(negedge PCLK);
    #1;
    chk("auto_zero_nkick", dq.size() - db, 0);
    auto_kick_en = 0;

    // reset during ACCESS of second start transfer, with a read pending
    chk("pre_rst_running", {63'b0, running}, 1);
    db = dq.size();
    pulse(1);
    rd_req = 1;
    @(negedge PCLK);
    rd_req = 0;
    @(negedge PCLK);
    chk("rst_seq_setup2", {54'b0, PADDR}, 64'h000);
    @(negedge PCLK);
    chk("rst_seq_access2", {63'b0, PENABLE}, 1);
    PRESET = 1;
    @(negedge PCLK);
    PRESET = 0;
    chk("midrst_psel", {63'b0, PSEL}, 0);
    chk("midrst_busy", {63'b0, busy}, 0);
    chk("midrst_running", {63'b0, running}, 0);
    idle_bad = 0;
    repeat (10) begin
      if (busy || PSEL) idle_bad++;
      @(negedge PCLK);
    end
    #1;
    chk("midrst_idle", idle_bad, 0);
    chk("midrst_nodone", dq.size() - db, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
